// File: rtl/agc_rupt_pkg.sv
// Shared definitions for the RUPT scheduler: scheduler states, source indices
// and the vector base, plus the vector address helper.
package agc_rupt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SERVE = 2'd2
    } rupt_state_e;

    localparam int T6RUPT   = 0;
    localparam int T5RUPT   = 1;
    localparam int T3RUPT   = 2;
    localparam int T4RUPT   = 3;
    localparam int KEYRUPT1 = 4;
    localparam int KEYRUPT2 = 5;
    localparam int UPRUPT   = 6;
    localparam int DOWNRUPT = 7;
    localparam int RADARUPT = 8;
    localparam int HANDRUPT = 9;

    localparam logic [11:0] VEC_BASE_DEF = 12'o4000;

    // Each source owns a 4-word slot; slot 0 is left for the base itself.
    function automatic logic [11:0] vec_addr(input logic [11:0] base, input logic [11:0] idx);
        return base + ((idx + 12'd1) << 2'd2);
    endfunction

endpackage

// File: rtl/rupt_prienc.sv
// Combinational lowest-index-wins priority encoder over the pending latches.
module rupt_prienc
#(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/rupt_sched.sv
// RUPT priority scheduler: latches requests, grants the highest-priority one at an
// instruction boundary, handshakes with the sequence generator and holds IIP until RESUME.
module rupt_sched
    import agc_rupt_pkg::*;
#(
    parameter int          NRUPT    = 10,
    parameter logic [11:0] VEC_BASE = VEC_BASE_DEF,
    parameter int          ACK_TMO  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NRUPT-1:0] RUPT_REQ,
    input  logic             INHINT,
    input  logic             OVNHRP,
    input  logic             EXST,
    input  logic             INSTB,
    input  logic             KRPT,
    input  logic             RESUME,
    input  logic             GOJAM,
    output logic             RPTSET,
    output logic [11:0]      RVEC,
    output logic             IIP,
    output logic [NRUPT-1:0] PEND,
    output logic             RPTERR
);

    localparam int IW = (NRUPT > 1) ? $clog2(NRUPT) : 1;
    localparam int CW = (ACK_TMO > 0) ? $clog2(ACK_TMO + 1) : 1;
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(ACK_TMO);
    localparam logic [NRUPT-1:0] BIT_ONE = NRUPT'(1);

    rupt_state_e      state_r;
    logic [NRUPT-1:0] pend_r;
    logic [IW-1:0]    ridx_r;
    logic [CW-1:0]    cnt_r;
    logic [11:0]      rvec_r;
    logic             iip_r;
    logic             rptset_r;
    logic             rpterr_r;

    logic [IW-1:0]    win_idx_s;
    logic             win_valid_s;
    logic [NRUPT-1:0] clr_s;
    logic [NRUPT-1:0] pend_next_s;
    logic             eligible_s;

    rupt_prienc #(
        .N  (NRUPT),
        .IW (IW)
    ) u_prienc (
        .req   (pend_r),
        .idx   (win_idx_s),
        .valid (win_valid_s)
    );

    // Pending-latch update (a new request beats the acknowledge clear) and grant qualification.
    always_comb begin
        clr_s       = (state_r == ARMED && KRPT) ? (BIT_ONE << ridx_r) : '0;
        pend_next_s = (pend_r & ~clr_s) | RUPT_REQ;
        eligible_s  = INSTB && win_valid_s && !INHINT && !OVNHRP && !EXST && (state_r == IDLE);
    end

    // Scheduler state machine with its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            pend_r   <= '0;
            ridx_r   <= '0;
            cnt_r    <= '0;
            rvec_r   <= 12'd0;
            iip_r    <= 1'b0;
            rptset_r <= 1'b0;
            rpterr_r <= 1'b0;
        end else if (GOJAM) begin
            state_r  <= IDLE;
            pend_r   <= '0;
            ridx_r   <= '0;
            cnt_r    <= '0;
            rvec_r   <= 12'd0;
            iip_r    <= 1'b0;
            rptset_r <= 1'b0;
            rpterr_r <= 1'b0;
        end else begin
            pend_r   <= pend_next_s;
            rptset_r <= 1'b0;
            rpterr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (eligible_s) begin
                        state_r  <= ARMED;
                        ridx_r   <= win_idx_s;
                        cnt_r    <= '0;
                        rptset_r <= 1'b1;
                    end
                end
                ARMED: begin
                    if (KRPT) begin
                        state_r <= SERVE;
                        rvec_r  <= vec_addr(VEC_BASE, 12'(ridx_r));
                        iip_r   <= 1'b1;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r  <= IDLE;
                        rpterr_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SERVE: begin
                    if (RESUME) begin
                        state_r <= IDLE;
                        iip_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    iip_r   <= 1'b0;
                end
            endcase
        end
    end

    assign RPTSET = rptset_r;
    assign RPTERR = rpterr_r;
    assign RVEC   = rvec_r;
    assign IIP    = iip_r;
    assign PEND   = pend_r;

endmodule
